// File: rtl/ads1256_sampler_pkg.sv
// Shared SPI/ADS1256 definitions: SPI core mode, ADS1256 command bytes,
// sampler state encoding and a counter-width helper.
package ads1256_sampler_pkg;

    // Direction of the byte the SPI core is currently moving
    typedef enum logic {
        SPI_TX = 1'b0,
        SPI_RX = 1'b1
    } spi_mode_t;

    // ADS1256 command opcodes
    localparam logic [7:0] CMD_RDATA  = 8'h01;
    localparam logic [7:0] CMD_RDATAC = 8'h03;
    localparam logic [7:0] CMD_SDATAC = 8'h0F;

    // Sampler sequencing states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DRDY = 3'd1,
        CMD       = 3'd2,
        CMD_WAIT  = 3'd3,
        T6        = 3'd4,
        RD        = 3'd5,
        RD_WAIT   = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Bits needed to count 0 .. n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ads1256_sampler_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops reset to RESET_VAL so the output starts in a known state.
module sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Resample the asynchronous input twice before anything uses it
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/ads1256_sampler.sv
// ADS1256 single/continuous sample sequencer. Waits for DRDY, issues RDATA,
// honours the t6 command-to-data delay, then reads three bytes through the
// external SPI byte core and presents a 24-bit two's complement sample.
module ads1256_sampler
    import ads1256_sampler_pkg::*;
#(
    parameter int unsigned T6_CYCLES    = 700,
    parameter int unsigned DRDY_TIMEOUT = 2_000_000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        continuous_i,
    input  logic        drdy_l_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_tx_o,
    output spi_mode_t   spi_mode_o,
    input  logic        spi_done_i,
    input  logic [7:0]  spi_rx_i,
    output logic        cs_l_o,
    output logic [23:0] sample_o,
    output logic        sample_valid_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int unsigned TMO_W = cnt_width(DRDY_TIMEOUT);
    localparam int unsigned T6_W  = cnt_width(T6_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRDY_TIMEOUT - 1);
    localparam logic [T6_W-1:0]  T6_LAST  = T6_W'(T6_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_drdy_l;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [T6_W-1:0]   r_t6_cnt;
    logic [1:0]        r_byte_cnt;
    // First two received bytes; the third completes the word on arrival
    logic [15:0]       r_shift;
    logic [23:0]       w_word;
    logic [23:0]       r_sample;
    logic              r_timeout;
    logic              w_tmo_hit;
    logic              w_t6_hit;
    logic              w_last_byte;
    logic              w_rx_byte;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_drdy_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (drdy_l_i),
        .q_o     (w_drdy_l)
    );

    assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
    assign w_t6_hit    = (r_t6_cnt == T6_LAST);
    assign w_last_byte = (r_byte_cnt == 2'd2);
    assign w_rx_byte   = (r_state == RD_WAIT) && spi_done_i;
    assign w_word      = {r_shift, spi_rx_i};

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode; spi_done_i only matters in the two wait states
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:      if (start_i || continuous_i) w_state_nx = WAIT_DRDY;
            WAIT_DRDY: begin
                if (!w_drdy_l)      w_state_nx = CMD;
                else if (w_tmo_hit) w_state_nx = IDLE;
            end
            CMD:       w_state_nx = CMD_WAIT;
            CMD_WAIT:  if (spi_done_i) w_state_nx = T6;
            T6:        if (w_t6_hit) w_state_nx = RD;
            RD:        w_state_nx = RD_WAIT;
            RD_WAIT:   if (spi_done_i) w_state_nx = w_last_byte ? DONE : RD;
            DONE:      w_state_nx = continuous_i ? WAIT_DRDY : IDLE;
            default:   w_state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the current state; CS stays low CMD..RD_WAIT
    always_comb begin
        spi_start_o    = 1'b0;
        spi_tx_o       = 8'h00;
        spi_mode_o     = SPI_TX;
        cs_l_o         = 1'b1;
        sample_valid_o = 1'b0;
        busy_o         = 1'b1;
        unique case (r_state)
            IDLE:      busy_o = 1'b0;
            WAIT_DRDY: busy_o = 1'b1;
            CMD: begin
                cs_l_o      = 1'b0;
                spi_start_o = 1'b1;
                spi_tx_o    = CMD_RDATA;
            end
            CMD_WAIT:  cs_l_o = 1'b0;
            T6:        cs_l_o = 1'b0;
            RD: begin
                cs_l_o      = 1'b0;
                spi_start_o = 1'b1;
                spi_mode_o  = SPI_RX;
            end
            RD_WAIT: begin
                cs_l_o     = 1'b0;
                spi_mode_o = SPI_RX;
            end
            DONE:      sample_valid_o = 1'b1;
            default:   busy_o = 1'b0;
        endcase
    end

    // Counters, byte assembly, sample register and sticky timeout flag
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_tmo_cnt  <= '0;
            r_t6_cnt   <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_sample   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == WAIT_DRDY) ? r_tmo_cnt + 1'b1 : '0;
            r_t6_cnt  <= (r_state == T6) ? r_t6_cnt + 1'b1 : '0;

            if (r_state == CMD) begin
                r_byte_cnt <= '0;
            end else if (w_rx_byte) begin
                r_shift    <= w_word[15:0];
                r_byte_cnt <= w_last_byte ? 2'd0 : r_byte_cnt + 2'd1;
            end

            // The sample is written as the last byte lands so it is already
            // stable during the DONE cycle that flags it valid
            if (w_rx_byte && w_last_byte) begin
                r_sample <= w_word;
            end

            if ((r_state == IDLE) && start_i) begin
                r_timeout <= 1'b0;
            end else if ((r_state == WAIT_DRDY) && w_drdy_l && w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign sample_o  = r_sample;
    assign timeout_o = r_timeout;

endmodule
